// File: rtl/data_memory_access_unit.sv
// rtl/data_memory_access_unit.sv - MEM-stage load/store bridge with req/ack memory handshake
// Aligns stores into byte lanes, stalls the pipeline while the access is in flight, right-aligns load data.
module data_memory_access_unit #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [2:0]            FUNC3,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic                  BUSY,
  output logic                  MISALIGNED,
  output logic                  BUS_ERROR,
  output logic [31:0]           READ_DATA_ALIGNED,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_WDATA,
  output logic [3:0]            MEM_BE,
  input  logic [31:0]           MEM_RDATA,
  input  logic                  MEM_ACK
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

  state_t                r_state;
  logic [31:0]           r_cnt;
  logic [1:0]            r_ofs;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_be;
  logic [31:0]           r_mem_wdata;
  logic [31:0]           r_rdata;
  logic                  r_bus_error;

  logic        w_req;
  logic        w_idle;
  logic        w_size_h;
  logic        w_size_w;
  logic        w_store_ok;
  logic        w_illegal;
  logic        w_mis_addr;
  logic        w_legal;
  logic        w_timeout;
  logic [1:0]  w_ofs;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_shifted;

  assign w_req      = MEM_READ | MEM_WRITE;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_ofs      = ADDRESS[1:0];
  assign w_size_h   = (FUNC3 == 3'b001) | (FUNC3 == 3'b101);
  assign w_size_w   = (FUNC3 == 3'b010);
  assign w_store_ok = (FUNC3 == 3'b000) | (FUNC3 == 3'b001) | (FUNC3 == 3'b010);
  assign w_illegal  = MEM_WRITE & ~w_store_ok;
  assign w_mis_addr = (w_size_h & ADDRESS[0]) | (w_size_w & (w_ofs != 2'b00));
  assign w_legal    = w_req & w_idle & ~w_illegal & ~w_mis_addr;

  // Flags are gated by reset so a request held during reset never stalls or traps.
  assign MISALIGNED = RESET_N & w_req & w_idle & ~w_illegal & w_mis_addr;
  assign BUSY       = RESET_N & (w_legal | (r_state == ST_ACCESS));

  assign w_timeout       = (LP_TIMEOUT != 32'd0) && ((r_cnt + 32'd1) == LP_TIMEOUT);
  assign w_rdata_shifted = MEM_RDATA >> {r_ofs, 3'b000};

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WRITE_DATA;
    if (MEM_WRITE) begin
      case (FUNC3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_ofs;
          w_wdata = {4{WRITE_DATA[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_ofs;
          w_wdata = {2{WRITE_DATA[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WRITE_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ofs       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            r_state     <= ST_ACCESS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= MEM_WRITE;
            r_mem_addr  <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_ofs       <= w_ofs;
            r_cnt       <= '0;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 32'd1;
          // An ack in the final allowed cycle wins over the timeout.
          if (MEM_ACK) begin
            if (!r_mem_we) begin
              r_rdata <= w_rdata_shifted;
            end
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_rdata     <= '0;
            r_bus_error <= 1'b1;
            r_state     <= ST_DONE;
            r_mem_req   <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUS_ERROR         = r_bus_error;
  assign READ_DATA_ALIGNED = r_rdata;
  assign MEM_REQ           = r_mem_req;
  assign MEM_WE            = r_mem_we;
  assign MEM_ADDR          = r_mem_addr;
  assign MEM_BE            = r_mem_be;
  assign MEM_WDATA         = r_mem_wdata;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// tb/tb_data_memory_access_unit.sv - scoreboard bench for data_memory_access_unit
// Driver pushes expected memory requests and completions; a negedge monitor pops and compares.
module tb_data_memory_access_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic        BUSY;
  logic        MISALIGNED;
  logic        BUS_ERROR;
  logic [31:0] READ_DATA_ALIGNED;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  data_memory_access_unit #(
    .TIMEOUT_CYCLES(4),
    .ADDR_WIDTH(32)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .FUNC3(FUNC3),
    .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .BUSY(BUSY),
    .MISALIGNED(MISALIGNED),
    .BUS_ERROR(BUS_ERROR),
    .READ_DATA_ALIGNED(READ_DATA_ALIGNED),
    .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_BE(MEM_BE),
    .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        berr;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // Monitor: a rising MEM_REQ opens a window, a falling one marks the DONE cycle.
  initial begin
    bit    prev;
    req_t  cur;
    done_t d;
    prev = 1'b0;
    cur  = '{addr: 32'd0, we: 1'b0, be: 4'd0, wdata: 32'd0, chk_wdata: 1'b0};
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        prev = 1'b0;
      end else begin
        if (MEM_REQ && !prev) begin
          if (req_q.size() == 0) fail_now("unexpected_req");
          else cur = req_q.pop_front();
        end
        if (MEM_REQ) begin
          check("mem_addr", MEM_ADDR, cur.addr);
          check("mem_we", 32'(MEM_WE), 32'(cur.we));
          check("mem_be", 32'(MEM_BE), 32'(cur.be));
          if (cur.chk_wdata) check("mem_wdata", MEM_WDATA, cur.wdata);
          check("busy_access", 32'(BUSY), 32'd1);
        end else if (prev) begin
          if (done_q.size() == 0) fail_now("unexpected_done");
          else begin
            d = done_q.pop_front();
            check("read_data", READ_DATA_ALIGNED, d.rdata);
            check("bus_error_done", 32'(BUS_ERROR), 32'(d.berr));
            check("busy_done", 32'(BUSY), 32'd0);
          end
        end else begin
          check("bus_error_idle", 32'(BUS_ERROR), 32'd0);
        end
        prev = MEM_REQ;
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of a later IDLE cycle.
  // dly 1..4 = ack in that ACCESS cycle, 5 = no ack (timeout after 4 cycles).
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int dly, input bit stray, input bit do_rst);
    int    kind;
    int    ofs;
    bit    ill;
    bit    mis;
    bit    legal;
    req_t  r;
    done_t d;
    kind  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    ill   = wr && (f3 > 3'd2);
    ofs   = int'(a % 4);
    mis   = !ill && ((kind == 2 && (a % 2) != 0) || (kind == 4 && ofs != 0));
    legal = (rd || wr) && !ill && !mis;
    MEM_READ   = rd;
    MEM_WRITE  = wr;
    FUNC3      = f3;
    ADDRESS    = a;
    WRITE_DATA = wd;
    @(negedge CLK);
    check("misaligned", 32'(MISALIGNED), 32'(mis));
    check("busy_request", 32'(BUSY), 32'(legal));
    if (legal) begin
      r.addr      = a - 32'(ofs);
      r.we        = wr;
      r.chk_wdata = wr;
      r.be        = 4'hF;
      r.wdata     = wd;
      if (wr) begin
        r.be = 4'(((1 << kind) - 1) << ofs);
        if (kind == 1) r.wdata = (wd % 256) * 32'h0101_0101;
        if (kind == 2) r.wdata = (wd % 65536) * 32'h0001_0001;
      end
      req_q.push_back(r);
    end
    @(posedge CLK); #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    if (legal) begin
      if (do_rst) begin
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check("rst_mem_req", 32'(MEM_REQ), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_read_data", READ_DATA_ALIGNED, 32'd0);
        @(negedge CLK);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        m_rdata = 32'd0;
      end else begin
        if (dly <= 4) begin
          repeat (dly - 1) begin
            @(posedge CLK); #1;
          end
          MEM_ACK   = 1'b1;
          MEM_RDATA = rdat;
          if (rd && !wr) m_rdata = rdat / (32'd1 << (8 * ofs));
          d.berr = 1'b0;
        end else begin
          repeat (3) begin
            @(posedge CLK); #1;
          end
          m_rdata = 32'd0;
          d.berr  = 1'b1;
        end
        d.rdata = m_rdata;
        done_q.push_back(d);
        @(posedge CLK); #1;
        MEM_ACK   = stray;
        MEM_RDATA = $urandom;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        if (stray) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = $urandom;
          @(posedge CLK); #1;
          MEM_ACK = 1'b0;
        end
      end
    end
  endtask

  initial begin
    RESET_N    = 1'b0;
    MEM_READ   = 1'b1;
    MEM_WRITE  = 1'b0;
    FUNC3      = 3'b010;
    ADDRESS    = 32'h0000_3001;
    WRITE_DATA = 32'd0;
    MEM_RDATA  = 32'd0;
    MEM_ACK    = 1'b0;
    #2;
    check("reset_misaligned", 32'(MISALIGNED), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_mem_req", 32'(MEM_REQ), 32'd0);
    check("reset_bus_error", 32'(BUS_ERROR), 32'd0);
    check("reset_read_data", READ_DATA_ALIGNED, 32'd0);
    check("reset_mem_be", 32'(MEM_BE), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    MEM_READ = 1'b0;
    RESET_N  = 1'b1;

    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'hA1B2_C3D4, 2, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'd0, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, 5, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_00AB, 32'd0, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'd0, 32'hBEEF_0000, 1, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h1111_1111, 32'd0, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'hCAFE_F00D, 32'd0, 3, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'd0, 32'h0102_0304, 1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'd0, 5, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom % 3);
      issue(sel != 1, sel != 0, 3'($urandom % 8), $urandom, $urandom, $urandom,
            int'($urandom_range(1, 5)), ($urandom % 4) == 0, ($urandom % 40) == 0);
    end

    repeat (3) @(posedge CLK);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_access_unit.md
Name: data_memory_access_unit

Overview:
MEM-stage bridge between the pipeline and the data memory, sitting directly upstream of the load processing unit.
- Accepts load/store requests, checks alignment and generates store byte-enables plus replicated write data.
- Runs a req/ack handshake with memory and stalls the pipeline while the access is in flight.
- Returns read data shifted so the addressed byte/halfword lands in bits [7:0]/[15:0], ready for sign/zero extension downstream.

Parameters:
TIMEOUT_CYCLES, 0, max cycles waiting for MEM_ACK before abort; 0 = wait forever
ADDR_WIDTH, 32, byte address width

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  reset, asynchronous, active-low
MEM_READ  input  1  load request from MEM stage
MEM_WRITE  input  1  store request from MEM stage
FUNC3  input  3  access size/type (000 B, 001 H, 010 W, 100 BU, 101 HU)
ADDRESS  input  ADDR_WIDTH  byte address from ALU
WRITE_DATA  input  32  store data, right-aligned
BUSY  output  1  pipeline stall request
MISALIGNED  output  1  misaligned-access flag (combinational)
BUS_ERROR  output  1  one-cycle pulse on access timeout
READ_DATA_ALIGNED  output  32  shifted read data, drives load unit DATA_OUT
MEM_REQ  output  1  memory request
MEM_WE  output  1  memory write enable
MEM_ADDR  output  ADDR_WIDTH  word address; bits [1:0] always 00
MEM_WDATA  output  32  lane-replicated store data
MEM_BE  output  4  byte enables
MEM_RDATA  input  32  memory read data
MEM_ACK  input  1  memory completion, single-cycle pulse

Behaviour:
- Reset (RESET_N low, asynchronous, including mid-access):
  - FSM goes to IDLE.
  - All registered outputs clear to 0 immediately.
  - MISALIGNED and BUSY are forced to 0 while RESET_N is low.
- Request: req = MEM_READ | MEM_WRITE. If both are high, the access is a write.
- Misalignment (IDLE only, combinational):
  - H/HU when ADDRESS[0] = 1.
  - W when ADDRESS[1:0] != 00.
  - B/BU is never misaligned.
- Store with FUNC3 not 000/001/010 is illegal: no access, BUSY = 0, no flag.
- Load with any other FUNC3 performs a full-word access. Output content is then the load unit's concern.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on a legal request, latch address, type, byte-enables and write data; go to ACCESS. On a misaligned or illegal request, stay in IDLE; MISALIGNED = 1 for misaligned.
  - ACCESS: MEM_REQ = 1; MEM_ADDR, MEM_WE, MEM_BE and MEM_WDATA are held stable. Wait counter increments each cycle.
    - On MEM_ACK: capture read data and go to DONE.
    - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without ACK: go to DONE, READ_DATA_ALIGNED <= 0, BUS_ERROR pulses for one cycle.
  - DONE: MEM_REQ = 0, BUSY = 0 for exactly one cycle so the pipeline advances; always return to IDLE. No new request is accepted in DONE.
- BUSY = (IDLE & legal request) | ACCESS. BUSY asserts combinationally in the request's first cycle.
- Latency: a memory ack in ACCESS cycle k gives DONE at cycle k+1. Minimum IDLE→ACCESS→DONE is 3 cycles per access. Back-to-back memory instructions incur one IDLE cycle between them.
- Byte enables and write data (ofs = ADDRESS[1:0]):
  - SB: MEM_BE = 0001 << ofs; MEM_WDATA = {4{WRITE_DATA[7:0]}}.
  - SH: MEM_BE = 0011 << ofs; MEM_WDATA = {2{WRITE_DATA[15:0]}}.
  - SW: MEM_BE = 1111; MEM_WDATA = WRITE_DATA.
  - Loads: MEM_BE = 1111, MEM_WE = 0.
- Read data: on ACK of a load, READ_DATA_ALIGNED <= MEM_RDATA >> (8*ofs), zero-filled from the top. The value holds until the next load ack, timeout or reset.
- Stores leave READ_DATA_ALIGNED unchanged.
- MEM_ACK is ignored in IDLE and DONE.
- MEM_ADDR = {latched ADDRESS[ADDR_WIDTH-1:2], 2'b00}.

Test Plan:
1. Reset: pulse RESET_N low mid-ACCESS -> MEM_REQ, BUSY and READ_DATA_ALIGNED drop to 0 immediately (before the next clock edge); FSM in IDLE after release.
2. LB at 0x1003, MEM_RDATA = 0xA1B2C3D4, ack after 2 cycles -> MEM_ADDR = 0x1000, MEM_BE = 1111, READ_DATA_ALIGNED = 0x000000A1; BUSY high 3 cycles then low in DONE.
3. SH at 0x2002 with WRITE_DATA = 0x12345678 -> MEM_WE = 1, MEM_BE = 1100, MEM_WDATA = 0x56785678, MEM_ADDR = 0x2000.
4. LW at 0x3001 -> MISALIGNED = 1, BUSY = 0, MEM_REQ never asserted; the same request at 0x3000 with MEM_RDATA = 0xDEADBEEF -> READ_DATA_ALIGNED = 0xDEADBEEF.
5. TIMEOUT_CYCLES = 4, load with no ack -> BUS_ERROR pulses once after 4 ACCESS cycles, READ_DATA_ALIGNED = 0, BUSY released in DONE.
6. Back-to-back SB 0x10 then LHU 0x12 (MEM_RDATA = 0xBEEF0000), plus a stray ack in IDLE -> two distinct MEM_REQ windows separated by DONE and IDLE, READ_DATA_ALIGNED = 0x0000BEEF, stray ack has no effect.
